// File: rtl/l2_cache_param_pkg.sv
// Shared types and default geometry for the parametrised L2 cache.
package l2_cache_param_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } l2_state_t;

  localparam int unsigned L2_WAYS   = 4;
  localparam int unsigned L2_SETS   = 16;
  localparam int unsigned LINE_BITS = 128;

endpackage

// File: rtl/l2_cache_param_plru.sv
// Tree pseudo-LRU for one set: victim lookup and touch update, purely combinational.
module plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim_way,
  output logic [WAYS-2:0]         bits_next
);
  import l2_cache_param_pkg::*;

  localparam int unsigned LVL = $clog2(WAYS);
  localparam int unsigned NB  = WAYS - 1;

  // Nodes are heap-ordered; at level l the node on a way's path is 2^l-1 plus that way's top l bits.
  always_comb begin
    logic [LVL-1:0] v;
    logic [NB-1:0]  b;
    logic [NB-1:0]  sh;
    logic [LVL-1:0] d;
    logic           away;
    int unsigned    node;
    v    = '0;
    b    = bits;
    sh   = '0;
    d    = '0;
    away = 1'b0;
    node = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      node = (32'd1 << l) - 32'd1 + 32'(v >> (LVL - l));
      sh   = bits >> node;
      v    = v | (LVL'(sh[0]) << (LVL - 1 - l));
    end
    for (int unsigned l = 0; l < LVL; l++) begin
      node = (32'd1 << l) - 32'd1 + 32'(touch_way >> (LVL - l));
      d    = touch_way >> (LVL - 1 - l);
      away = ~d[0];
      b    = (b & ~(NB'(1) << node)) | (NB'(away) << node);
    end
    victim_way = v;
    bits_next  = b;
  end

endmodule

// File: rtl/l2_cache_param.sv
// Write-back, write-allocate set-associative L2 with tree PLRU and saturating hit/miss counters.
module l2_cache_param #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_BITS  = l2_cache_param_pkg::LINE_BITS,
  parameter int unsigned WAYS       = l2_cache_param_pkg::L2_WAYS,
  parameter int unsigned SETS       = l2_cache_param_pkg::L2_SETS,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_BITS-1:0]  mem_wdata,
  output logic [LINE_BITS-1:0]  mem_rdata,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_BITS-1:0]  pmem_wdata,
  input  logic [LINE_BITS-1:0]  pmem_rdata,
  input  logic                  pmem_resp,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  import l2_cache_param_pkg::*;

  localparam int unsigned OFF_W = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

  if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("l2_cache_param: WAYS must be a power of 2 and at least 2");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("l2_cache_param: SETS must be a power of 2 and at least 2");
  end
  if (LINE_BITS < 16 || (LINE_BITS & (LINE_BITS - 1)) != 0) begin : g_bad_line
    $error("l2_cache_param: LINE_BITS must be a power of 2 and at least 16");
  end
  if (ADDR_WIDTH <= IDX_W + OFF_W) begin : g_bad_addr
    $error("l2_cache_param: ADDR_WIDTH leaves no tag bits");
  end

  l2_state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [LINE_BITS-1:0]      data_q [SETS][WAYS];

  // Miss context captured on the IDLE->miss edge
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_req_q;
  logic [WAY_W-1:0] victim_q;
  logic             write_q;

  logic             req;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_offset;

  assign req           = mem_read | mem_write;
  assign idx           = mem_address[OFF_W +: IDX_W];
  assign req_tag       = mem_address[ADDR_WIDTH-1 -: TAG_W];
  assign unused_offset = ^mem_address[OFF_W-1:0];

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 inv_any;
  logic [WAY_W-1:0]     inv_way;
  logic [LINE_BITS-1:0] hit_data;

  // Tag match and lowest invalid way for the presented index
  always_comb begin
    logic [WAY_W-1:0] wi;
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    wi      = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      wi = WAY_W'(w);
      if (valid_q[idx][wi] && tag_q[idx][wi] == req_tag) begin
        hit     = 1'b1;
        hit_way = wi;
      end
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      wi = WAY_W'(w - 1);
      if (!valid_q[idx][wi]) begin
        inv_any = 1'b1;
        inv_way = wi;
      end
    end
    hit_data = data_q[idx][hit_way];
  end

  logic [IDX_W-1:0] plru_idx;
  logic [WAY_W-1:0] touch_way;
  logic [WAY_W-1:0] plru_victim;
  logic [WAYS-2:0]  plru_next;
  logic [WAY_W-1:0] victim_c;

  assign plru_idx  = (state_q == IDLE) ? idx : idx_q;
  assign touch_way = (state_q == IDLE) ? hit_way : victim_q;
  assign victim_c  = inv_any ? inv_way : plru_victim;

  plru_tree #(
    .WAYS (WAYS)
  ) u_plru (
    .bits       (plru_q[plru_idx]),
    .touch_way  (touch_way),
    .victim_way (plru_victim),
    .bits_next  (plru_next)
  );

  logic hit_evt;
  logic miss_evt;
  logic fill_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all request/memory outputs; mem_resp is combinational by design
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = hit_data;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag_req_q, idx_q, OFF_W'(0)};
    pmem_wdata   = data_q[idx_q][victim_q];
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    fill_evt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            hit_evt  = 1'b1;
          end else begin
            miss_evt = 1'b1;
            state_d  = (valid_q[idx][victim_c] && dirty_q[idx][victim_c]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx_q][victim_q], idx_q, OFF_W'(0)};
        if (pmem_resp) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        mem_rdata = pmem_rdata;
        if (pmem_resp) begin
          mem_resp = 1'b1;
          fill_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status bits, PLRU and counters: flash-cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      plru_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_evt && hit_count != '1) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (miss_evt && miss_count != '1) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
      if (hit_evt && mem_write) begin
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (fill_evt) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        dirty_q[idx_q][victim_q] <= write_q;
      end
      if (hit_evt || fill_evt) begin
        plru_q[plru_idx] <= plru_next;
      end
    end
  end

  // Tag/data arrays and miss context carry no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (miss_evt) begin
        idx_q     <= idx;
        tag_req_q <= req_tag;
        victim_q  <= victim_c;
        write_q   <= mem_write;
      end
      if (hit_evt && mem_write) begin
        data_q[idx][hit_way] <= mem_wdata;
      end
      if (fill_evt) begin
        tag_q[idx_q][victim_q]  <= tag_req_q;
        data_q[idx_q][victim_q] <= write_q ? mem_wdata : pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_l2_cache_param.sv
// Directed bench for l2_cache_param with a line-level cache/memory model and per-cycle compare.
module tb_l2_cache_param;

  localparam int unsigned NW   = 4;
  localparam int unsigned NS   = 16;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  l2_cache_param #(
    .ADDR_WIDTH (16),
    .LINE_BITS  (128),
    .WAYS       (NW),
    .SETS       (NS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  // Model: per-line contents, per-set PLRU tree nodes (heap order), backing memory
  bit           m_valid [NS][NW];
  bit           m_dirty [NS][NW];
  logic [7:0]   m_tag   [NS][NW];
  logic [127:0] m_data  [NS][NW];
  bit           m_plru  [NS][NW-1];
  int           m_hits;
  int           m_misses;
  logic [127:0] bmem [logic [15:0]];

  // Per-cycle expectations set by the driver
  bit           chk_en = 1'b0;
  bit           exp_resp, exp_pr, exp_pw, exp_rd;
  logic [127:0] exp_rdata, exp_wb_data;
  logic [15:0]  exp_wb_addr, exp_fill_addr;

  logic [127:0] cap_rdata, cap_wb_data;
  logic [15:0]  cap_wb_addr, cap_fill_addr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  function automatic logic [127:0] mem_line(input logic [15:0] la);
    if (bmem.exists(la)) return bmem[la];
    return {8{la}};
  endfunction

  function automatic int plru_victim(input int s);
    int node = 0;
    while (node < NW - 1) node = 2 * node + 1 + int'(m_plru[s][node]);
    return node - (NW - 1);
  endfunction

  task automatic plru_touch(input int s, input int w);
    int node = w + NW - 1;
    int parent;
    while (node > 0) begin
      parent = (node - 1) / 2;
      m_plru[s][parent] = (node == 2 * parent + 1);
      node = parent;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 1'b0;
    end
    m_hits = 0; m_misses = 0;
    exp_resp = 0; exp_pr = 0; exp_pw = 0; exp_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_resp", 128'(mem_resp), 128'(exp_resp));
      check("pmem_read", 128'(pmem_read), 128'(exp_pr));
      check("pmem_write", 128'(pmem_write), 128'(exp_pw));
      check("hit_count", 128'(hit_count), 128'(m_hits));
      check("miss_count", 128'(miss_count), 128'(m_misses));
      if (exp_pw) begin
        check("wb_addr", 128'(pmem_address), 128'(exp_wb_addr));
        check("wb_data", pmem_wdata, exp_wb_data);
        cap_wb_addr = pmem_address;
        cap_wb_data = pmem_wdata;
      end
      if (exp_pr) begin
        check("fill_addr", 128'(pmem_address), 128'(exp_fill_addr));
        cap_fill_addr = pmem_address;
      end
      if (exp_resp && exp_rd) begin
        check("rdata", mem_rdata, exp_rdata);
        cap_rdata = mem_rdata;
      end
    end
  end

  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] wd, input int lat);
    int s, w;
    bit hit;
    logic [7:0] t;
    logic [15:0] la;
    logic [127:0] fd;
    s  = int'(addr[7:4]);
    t  = addr[15:8];
    la = {addr[15:4], 4'h0};
    hit = 1'b0; w = 0;
    for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == t) begin hit = 1'b1; w = i; end
    cap_rdata = '0; cap_wb_data = '0; cap_wb_addr = '0; cap_fill_addr = '0;
    mem_read = !wr; mem_write = wr; mem_address = addr; mem_wdata = wd; exp_rd = !wr;
    if (hit) begin
      exp_resp = 1'b1; exp_rdata = m_data[s][w];
      step();
      m_hits = sat(m_hits);
      if (wr) begin m_data[s][w] = wd; m_dirty[s][w] = 1'b1; end
      plru_touch(s, w);
    end else begin
      w = -1;
      for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = plru_victim(s);
      step();
      m_misses = sat(m_misses);
      if (m_valid[s][w] && m_dirty[s][w]) begin
        exp_pw = 1'b1;
        exp_wb_addr = {m_tag[s][w], addr[7:4], 4'h0};
        exp_wb_data = m_data[s][w];
        for (int i = 0; i < lat; i++) begin pmem_resp = (i == lat - 1); step(); end
        bmem[exp_wb_addr] = exp_wb_data;
        exp_pw = 1'b0; pmem_resp = 1'b0;
      end
      fd = mem_line(la);
      exp_pr = 1'b1; exp_fill_addr = la;
      for (int i = 0; i < lat; i++) begin
        if (i == lat - 1) begin
          pmem_resp = 1'b1; pmem_rdata = fd; exp_resp = 1'b1; exp_rdata = fd;
        end
        step();
      end
      m_valid[s][w] = 1'b1; m_tag[s][w] = t; m_dirty[s][w] = wr;
      m_data[s][w] = wr ? wd : fd;
      plru_touch(s, w);
    end
    mem_read = 0; mem_write = 0; pmem_resp = 0; pmem_rdata = {4{32'hDEAD_BEEF}};
    exp_resp = 0; exp_pr = 0; exp_pw = 0;
  endtask

  localparam logic [127:0] LINE_A = {8{16'h1230}};
  localparam logic [127:0] LINE_B = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
  localparam logic [127:0] LINE_W = 128'h5A5A_0001_0203_0405_0607_0809_0A0B_0C0D;
  localparam logic [127:0] LINE_C = 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    check("rst_hit_count", 128'(hit_count), 128'd0);
    check("rst_miss_count", 128'(miss_count), 128'd0);

    do_req(0, 16'h1230, '0, 2);
    check("first_read_data", cap_rdata, LINE_A);
    check("first_miss_count", 128'(miss_count), 128'd1);
    do_req(0, 16'h1230, '0, 2);
    check("hit_read_data", cap_rdata, LINE_A);
    check("hit_count_one", 128'(hit_count), 128'd1);

    do_req(1, 16'h1230, LINE_B, 1);
    do_req(0, 16'h0130, '0, 1);
    do_req(0, 16'h2130, '0, 3);
    do_req(0, 16'h3130, '0, 1);
    do_req(0, 16'h4130, '0, 2);
    check("evict_wb_addr", 128'(cap_wb_addr), 128'h1230);
    check("evict_wb_data", cap_wb_data, LINE_B);
    check("evict_fill_addr", 128'(cap_fill_addr), 128'h4130);

    do_req(1, 16'h5000, LINE_W, 2);
    check("wmiss_no_wb", 128'(cap_wb_addr), 128'h0);
    do_req(0, 16'h6000, '0, 1);
    do_req(0, 16'h7000, '0, 1);
    do_req(0, 16'h8000, '0, 1);
    do_req(0, 16'h9000, '0, 2);
    check("wmiss_wb_addr", 128'(cap_wb_addr), 128'h5000);
    check("wmiss_wb_data", cap_wb_data, LINE_W);

    do_req(0, 16'h1230, '0, 3);
    check("refetch_data", cap_rdata, LINE_B);

    // Abandon a fill with reset while pmem_read is pending
    mem_read = 1; mem_address = 16'h7770; exp_rd = 1;
    step();
    m_misses = sat(m_misses); exp_pr = 1; exp_fill_addr = 16'h7770;
    step();
    rst = 1; mem_read = 0;
    step();
    rst = 0;
    model_reset();
    check("abort_pmem_read", 128'(pmem_read), 128'd0);
    check("abort_miss_count", 128'(miss_count), 128'd0);
    step();
    do_req(0, 16'h7770, '0, 2);
    check("reissue_miss_count", 128'(miss_count), 128'd1);
    check("reissue_data", cap_rdata, {8{16'h7770}});

    do_req(1, 16'h7770, LINE_C, 1);
    do_req(0, 16'h7770, '0, 1);
    check("write_hit_readback", cap_rdata, LINE_C);

    for (int i = 0; i < 20; i++) do_req(0, 16'h7770, '0, 1);
    check("hit_saturated", 128'(hit_count), 128'd15);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
